// File: rtl/text_scroll_engine_if.sv
// Bus bundle between the scroll/clear engine and its surroundings:
// command inputs, the shared character-memory port and status flags.
//   slave  : engine side (receives commands and read data, drives memory/status)
//   master : host/memory side (drives commands, slot grant and read data)
// Signals:
//   start_scroll, start_clear : 1-cycle command pulses
//   fill_char                 : fill byte, sampled when a command is accepted
//   slot_ok                   : memory port free for the engine this cycle
//   mem_rdata                 : read data, valid the cycle after mem_re
//   mem_addr/mem_re/mem_we/mem_wdata : memory port
//   busy, done                : engine active / 1-cycle completion pulse
interface text_scroll_engine_if #(
  parameter int unsigned ADDR_W = 13
);
  logic              start_scroll;
  logic              start_clear;
  logic [7:0]        fill_char;
  logic              slot_ok;
  logic [7:0]        mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              done;

  modport slave (
    input  start_scroll, start_clear, fill_char, slot_ok, mem_rdata,
    output mem_addr, mem_re, mem_we, mem_wdata, busy, done
  );

  modport master (
    output start_scroll, start_clear, fill_char, slot_ok, mem_rdata,
    input  mem_addr, mem_re, mem_we, mem_wdata, busy, done
  );
endinterface

// File: rtl/text_scroll_engine.sv
// Scroll/clear engine for the text-display character memory.
// Scroll: copies every cell up one text row (read cell dst+COLS, write cell dst),
// then fills the last row with the latched fill byte. Clear: fills every cell.
// Memory accesses happen only in cycles where slot_ok grants the port.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset (aborts any run, no done pulse)
//   bus   : text_scroll_engine_if.slave (commands, memory port, busy/done)
module text_scroll_engine #(
  parameter int unsigned COLS   = 100,
  parameter int unsigned ROWS   = 36,
  parameter int unsigned BASE   = 0,
  parameter int unsigned ADDR_W = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  text_scroll_engine_if.slave   bus
);

  localparam int unsigned NCELL = COLS * ROWS;
  localparam int unsigned DW    = $clog2(NCELL + 1);

  localparam logic [DW-1:0]     LAST_COPY = DW'(COLS * (ROWS - 1) - 1);
  localparam logic [DW-1:0]     LAST_FILL = DW'(NCELL - 1);
  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_WRITE,
    S_FILL,
    S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DW-1:0]     r_dst,   w_dst_nxt;
  logic [7:0]        r_data,  w_data_nxt;
  logic [7:0]        r_fch,   w_fch_nxt;
  logic [ADDR_W-1:0] w_dst_addr;
  logic [ADDR_W-1:0] w_src_addr;

  // Address arithmetic is done at ADDR_W so BASE+index truncates naturally.
  assign w_dst_addr = BASE_A + ADDR_W'(r_dst);
  assign w_src_addr = w_dst_addr + COLS_A;

  always_comb begin
    w_state_nxt   = r_state;
    w_dst_nxt     = r_dst;
    w_data_nxt    = r_data;
    w_fch_nxt     = r_fch;
    bus.mem_addr  = '0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.busy      = (r_state != S_IDLE);
    bus.done      = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Scroll has priority when both commands arrive together.
        if (bus.start_scroll) begin
          w_fch_nxt   = bus.fill_char;
          w_dst_nxt   = '0;
          w_state_nxt = S_READ;
        end else if (bus.start_clear) begin
          w_fch_nxt   = bus.fill_char;
          w_dst_nxt   = '0;
          w_state_nxt = S_FILL;
        end
      end
      S_READ: begin
        if (bus.slot_ok) begin
          bus.mem_re   = 1'b1;
          bus.mem_addr = w_src_addr;
          w_state_nxt  = S_CAPT;
        end
      end
      S_CAPT: begin
        // Read data is valid exactly one cycle after mem_re; no slot needed.
        w_data_nxt  = bus.mem_rdata;
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (bus.slot_ok) begin
          bus.mem_we    = 1'b1;
          bus.mem_addr  = w_dst_addr;
          bus.mem_wdata = r_data;
          w_dst_nxt     = r_dst + 1'b1;
          w_state_nxt   = (r_dst == LAST_COPY) ? S_FILL : S_READ;
        end
      end
      S_FILL: begin
        if (bus.slot_ok) begin
          bus.mem_we    = 1'b1;
          bus.mem_addr  = w_dst_addr;
          bus.mem_wdata = r_fch;
          if (r_dst == LAST_FILL) begin
            w_state_nxt = S_DONE;
          end else begin
            w_dst_nxt   = r_dst + 1'b1;
          end
        end
      end
      S_DONE: begin
        bus.done    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_dst   <= '0;
      r_data  <= '0;
      r_fch   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dst   <= w_dst_nxt;
      r_data  <= w_data_nxt;
      r_fch   <= w_fch_nxt;
    end
  end

endmodule

// File: tb/tb_text_scroll_engine.sv
// Self-checking bench for text_scroll_engine (COLS=4, ROWS=3, BASE=16).
// A table of command runs is applied in a loop; reset-abort is a hand sequence.
module tb_text_scroll_engine;

  localparam int unsigned COLS   = 4;
  localparam int unsigned ROWS   = 3;
  localparam int unsigned BASE   = 16;
  localparam int unsigned ADDR_W = 13;

  logic clk = 1'b0;
  logic reset;
  logic load;
  logic [7:0] mem [0:8191];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit gated  = 1'b0;

  always #10 clk = ~clk;

  text_scroll_engine_if #(.ADDR_W(ADDR_W)) bus ();

  text_scroll_engine #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .BASE  (BASE),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Character memory model: 1-cycle read latency; cell i (address 16+i) holds i.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 8192; i++)
        mem[i] <= (i >= 16 && i < 28) ? 8'(i - 16) : 8'hEE;
    end else begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  typedef struct {
    string      name;
    bit         sc;
    bit         cl;
    logic [7:0] fc;
    logic [7:0] fc_after;
    bit         gated;
    int         clr_pulse_at;
    int         exp_done;
    int         exp_re;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    bus.slot_ok = gated ? ((cyc % 8) < 2) : 1'b1;
  endtask

  task automatic init_mem();
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic check_mem(input string name, input bit scroll, input logic [7:0] fc);
    logic [7:0] e;
    for (int a = 15; a <= 28; a++) begin
      if (a < 16 || a > 27)  e = 8'hEE;
      else if (scroll)       e = (a - 16 < 8) ? 8'(a - 16 + 4) : fc;
      else                   e = fc;
      check($sformatf("%s mem[%0d]", name, a), 32'(mem[a]), 32'(e));
    end
  endtask

  task automatic run(input vec_t v);
    int done_at = -1;
    int done_n  = 0;
    int busy_n  = 0;
    int re_n    = 0;
    int viol    = 0;
    gated = v.gated;
    init_mem();
    bus.start_scroll = v.sc;
    bus.start_clear  = v.cl;
    bus.fill_char    = v.fc;
    for (int k = 1; k <= 600; k++) begin
      step();
      bus.start_scroll = 1'b0;
      bus.start_clear  = (k == v.clr_pulse_at);
      bus.fill_char    = v.fc_after;
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      if (bus.mem_re) re_n++;
      if ((bus.mem_re || bus.mem_we) && !bus.slot_ok) viol++;
      if (bus.mem_re && bus.mem_we) viol++;
      if (done_at >= 0 && k >= done_at + 3) break;
    end
    bus.start_clear = 1'b0;
    if (v.exp_done >= 0) check({v.name, " done cycle"}, 32'(done_at), 32'(v.exp_done));
    check({v.name, " busy cycles"}, 32'(busy_n), 32'(done_at));
    check({v.name, " done pulses"}, 32'(done_n), 32'd1);
    check({v.name, " read count"}, 32'(re_n), 32'(v.exp_re));
    check({v.name, " strobe violations"}, 32'(viol), 32'd0);
    check_mem(v.name, v.sc, v.fc);
    gated = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int done_n;
    int busy_n;
    vec_t clr;

    tbl[0] = '{"scroll",    1'b1, 1'b0, 8'h20, 8'h20, 1'b0, 0,  29, 8};
    tbl[1] = '{"clear",     1'b0, 1'b1, 8'h2E, 8'h2E, 1'b0, 0,  13, 0};
    tbl[2] = '{"gated",     1'b1, 1'b0, 8'h20, 8'h20, 1'b1, 0,  -1, 8};
    tbl[3] = '{"both+busy", 1'b1, 1'b1, 8'h20, 8'h20, 1'b0, 5,  29, 8};
    tbl[4] = '{"fill_hold", 1'b1, 1'b0, 8'h20, 8'h41, 1'b0, 0,  29, 8};

    reset            = 1'b1;
    load             = 1'b0;
    bus.start_scroll = 1'b0;
    bus.start_clear  = 1'b0;
    bus.fill_char    = 8'h00;
    bus.slot_ok      = 1'b1;
    step();
    step();
    @(negedge clk);
    check("reset busy",  32'(bus.busy),      32'd0);
    check("reset done",  32'(bus.done),      32'd0);
    check("reset re",    32'(bus.mem_re),    32'd0);
    check("reset we",    32'(bus.mem_we),    32'd0);
    check("reset addr",  32'(bus.mem_addr),  32'd0);
    check("reset wdata", 32'(bus.mem_wdata), 32'd0);
    step();
    reset = 1'b0;

    for (int t = 0; t < 5; t++) run(tbl[t]);

    // Reset mid-scroll: cycle 16 is the READ of cell 5 (dst=5).
    init_mem();
    bus.start_scroll = 1'b1;
    bus.fill_char    = 8'h20;
    for (int k = 1; k <= 16; k++) begin
      step();
      bus.start_scroll = 1'b0;
    end
    check("pre-abort busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort busy", 32'(bus.busy),   32'd0);
    check("abort we",   32'(bus.mem_we), 32'd0);
    check("abort re",   32'(bus.mem_re), 32'd0);
    step();
    reset  = 1'b0;
    done_n = 0;
    busy_n = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      @(negedge clk);
      if (bus.done) done_n++;
      if (bus.busy) busy_n++;
    end
    check("abort no done", 32'(done_n), 32'd0);
    check("abort idle",    32'(busy_n), 32'd0);
    check("abort cell4 copied", 32'(mem[20]), 32'd8);
    check("abort cell5 intact", 32'(mem[21]), 32'd5);
    check("abort last row",     32'(mem[27]), 32'd11);

    clr = '{"post-abort clear", 1'b0, 1'b1, 8'h2E, 8'h2E, 1'b0, 0, 13, 0};
    run(clr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
